// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam logic [InstAddrBus-1:0] DefResetAddr = '0;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StFull,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory request/ack, redirect and decode-side valid/ready signals of the fetch stage.
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBus,
    parameter int unsigned INST_W = InstBus
);
    logic              branch_true;
    logic [ADDR_W-1:0] new_addr;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;

    modport master (
        input  branch_true, new_addr, imem_ack, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_inst
    );

    modport slave (
        output branch_true, new_addr, imem_ack, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_inst
    );
endinterface

// File: rtl/fetch_slot.sv
// Output register toward decode: captures one fetched instruction, clears on flush/consume.
module fetch_slot
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBus,
    parameter int unsigned INST_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o
);
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    // Holding is the default; clear only drops valid and leaves pc/inst as they were.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (capture_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem handshake and applies branch redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned     ADDR_W     = InstAddrBus,
    parameter int unsigned     INST_W     = InstBus,
    parameter logic [ADDR_W-1:0] RESET_ADDR = DefResetAddr
) (
    input  logic clk,
    input  logic rst,
    fetch_ctrl_if.master bus_io
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              capture;
    logic              clear;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        capture = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                if (bus_io.branch_true) begin
                    clear = 1'b1;
                    pc_d  = bus_io.new_addr;
                end
            end
            StFetch: begin
                if (bus_io.branch_true) begin
                    clear = 1'b1;
                    if (bus_io.imem_ack) begin
                        pc_d = bus_io.new_addr;
                    end else begin
                        // Old address must stay on the bus until its ack arrives.
                        tgt_d   = bus_io.new_addr;
                        state_d = StDrain;
                    end
                end else if (bus_io.imem_ack) begin
                    capture = 1'b1;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StFull;
                end
            end
            StFull: begin
                if (bus_io.branch_true) begin
                    clear   = 1'b1;
                    pc_d    = bus_io.new_addr;
                    state_d = StFetch;
                end else if (bus_io.if_ready) begin
                    clear   = 1'b1;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (bus_io.branch_true) begin
                    clear = 1'b1;
                    if (bus_io.imem_ack) begin
                        pc_d    = bus_io.new_addr;
                        state_d = StFetch;
                    end else begin
                        tgt_d = bus_io.new_addr;
                    end
                end else if (bus_io.imem_ack) begin
                    pc_d    = tgt_q;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_ADDR;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bus_io.imem_req  = (state_q == StFetch) || (state_q == StDrain);
    assign bus_io.imem_addr = pc_q;

    fetch_slot #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W)
    ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .capture_i(capture),
        .clear_i  (clear),
        .pc_i     (pc_q),
        .inst_i   (bus_io.imem_rdata),
        .valid_o  (bus_io.if_valid),
        .pc_o     (bus_io.if_pc),
        .inst_o   (bus_io.if_inst)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed per-cycle vector bench for fetch_ctrl with hand-computed expectations.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    typedef struct {
        logic        br;
        logic [31:0] na;
        logic        ack;
        logic [31:0] rd;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    vec_t vecs[$];

    fetch_ctrl_if #(.ADDR_W(32), .INST_W(32)) bus ();

    fetch_ctrl #(
        .ADDR_W    (32),
        .INST_W    (32),
        .RESET_ADDR(32'h0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic br, input logic [31:0] na, input logic ack,
                       input logic [31:0] rd, input logic rdy, input logic req,
                       input logic [31:0] addr, input logic vld, input logic [31:0] pc,
                       input logic [31:0] inst);
        vec_t v;
        v.br = br; v.na = na; v.ack = ack; v.rd = rd; v.rdy = rdy;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.inst = inst;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.branch_true = v.br;
        bus.new_addr    = v.na;
        bus.imem_ack    = v.ack;
        bus.imem_rdata  = v.rd;
        bus.if_ready    = v.rdy;
    endtask

    task automatic check(input string name, input vec_t v);
        n_vec++;
        if (bus.imem_req !== v.req || bus.imem_addr !== v.addr || bus.if_valid !== v.vld ||
            bus.if_pc !== v.pc || bus.if_inst !== v.inst) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h inst=%h, want req=%b addr=%h valid=%b pc=%h inst=%h",
                     name, bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_pc, bus.if_inst,
                     v.req, v.addr, v.vld, v.pc, v.inst);
        end
    endtask

    // One cycle: drive inputs, compare outputs mid-cycle, then step past the edge.
    task automatic cycle(input string name, input vec_t v);
        drive(v);
        @(negedge clk);
        check(name, v);
        @(posedge clk);
        #1;
    endtask

    task automatic hand(input string name, input logic br, input logic [31:0] na,
                        input logic ack, input logic [31:0] rd, input logic rdy,
                        input logic req, input logic [31:0] addr, input logic vld,
                        input logic [31:0] pc, input logic [31:0] inst);
        vec_t v;
        v.br = br; v.na = na; v.ack = ack; v.rd = rd; v.rdy = rdy;
        v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.inst = inst;
        cycle(name, v);
    endtask

    initial begin
        vec_t z;
        n_vec = 0;
        n_bad = 0;

        //  br  new_addr      ack rdata         rdy | req addr          vld pc            inst
        add(0, 32'h0,         1, 32'hA000_0000, 1,   1, 32'h0,         0, 32'h0,         32'h0);
        add(0, 32'h0,         0, 32'h0,         1,   0, 32'h1,         1, 32'h0,         32'hA000_0000);
        add(0, 32'h0,         1, 32'hA000_0001, 1,   1, 32'h1,         0, 32'h0,         32'hA000_0000);
        add(0, 32'h0,         0, 32'h0,         1,   0, 32'h2,         1, 32'h1,         32'hA000_0001);
        add(0, 32'h0,         1, 32'hA000_0002, 1,   1, 32'h2,         0, 32'h1,         32'hA000_0001);
        add(0, 32'h0,         0, 32'h0,         1,   0, 32'h3,         1, 32'h2,         32'hA000_0002);
        add(0, 32'h0,         1, 32'hA000_0003, 1,   1, 32'h3,         0, 32'h2,         32'hA000_0002);
        add(0, 32'h0,         0, 32'h0,         1,   0, 32'h4,         1, 32'h3,         32'hA000_0003);
        add(0, 32'h0,         1, 32'hA000_0004, 1,   1, 32'h4,         0, 32'h3,         32'hA000_0003);
        add(0, 32'h0,         0, 32'h0,         1,   0, 32'h5,         1, 32'h4,         32'hA000_0004);
        // late ack: address 5 held for three wait cycles
        add(0, 32'h0,         0, 32'h0,         1,   1, 32'h5,         0, 32'h4,         32'hA000_0004);
        add(0, 32'h0,         0, 32'h0,         1,   1, 32'h5,         0, 32'h4,         32'hA000_0004);
        add(0, 32'h0,         0, 32'h0,         1,   1, 32'h5,         0, 32'h4,         32'hA000_0004);
        add(0, 32'h0,         1, 32'hB000_0005, 1,   1, 32'h5,         0, 32'h4,         32'hA000_0004);
        // decode stall for four cycles
        add(0, 32'h0,         0, 32'h0,         0,   0, 32'h6,         1, 32'h5,         32'hB000_0005);
        add(0, 32'h0,         0, 32'h0,         0,   0, 32'h6,         1, 32'h5,         32'hB000_0005);
        add(0, 32'h0,         0, 32'h0,         0,   0, 32'h6,         1, 32'h5,         32'hB000_0005);
        add(0, 32'h0,         0, 32'h0,         0,   0, 32'h6,         1, 32'h5,         32'hB000_0005);
        add(0, 32'h0,         0, 32'h0,         1,   0, 32'h6,         1, 32'h5,         32'hB000_0005);
        add(0, 32'h0,         1, 32'hA000_0006, 1,   1, 32'h6,         0, 32'h5,         32'hB000_0005);
        add(0, 32'h0,         0, 32'h0,         1,   0, 32'h7,         1, 32'h6,         32'hA000_0006);
        // redirect while request to 7 pending; ack two cycles later is dropped
        add(1, 32'h40,        0, 32'h0,         1,   1, 32'h7,         0, 32'h6,         32'hA000_0006);
        add(0, 32'h0,         0, 32'h0,         1,   1, 32'h7,         0, 32'h6,         32'hA000_0006);
        add(0, 32'h0,         1, 32'hDEAD_0007, 1,   1, 32'h7,         0, 32'h6,         32'hA000_0006);
        // redirect into DRAIN, then a newer redirect inside DRAIN wins
        add(1, 32'h100,       0, 32'h0,         1,   1, 32'h40,        0, 32'h6,         32'hA000_0006);
        add(1, 32'h80,        0, 32'h0,         1,   1, 32'h40,        0, 32'h6,         32'hA000_0006);
        add(0, 32'h0,         1, 32'hBAD0_0040, 1,   1, 32'h40,        0, 32'h6,         32'hA000_0006);
        add(0, 32'h0,         1, 32'hC000_0080, 1,   1, 32'h80,        0, 32'h6,         32'hA000_0006);
        // redirect in FULL with ready: flush wins
        add(1, 32'h200,       0, 32'h0,         1,   0, 32'h81,        1, 32'h80,        32'hC000_0080);
        // redirect with same-cycle ack, twice
        add(1, 32'h300,       1, 32'h1111_1111, 1,   1, 32'h200,       0, 32'h80,        32'hC000_0080);
        add(1, 32'hFFFF_FFFF, 1, 32'h2222_2222, 1,   1, 32'h300,       0, 32'h80,        32'hC000_0080);
        // all-ones address wraps to 0
        add(0, 32'h0,         1, 32'hD000_0000, 1,   1, 32'hFFFF_FFFF, 0, 32'h80,        32'hC000_0080);
        add(0, 32'h0,         0, 32'h0,         1,   0, 32'h0,         1, 32'hFFFF_FFFF, 32'hD000_0000);
        add(0, 32'h0,         1, 32'hE000_0000, 1,   1, 32'h0,         0, 32'hFFFF_FFFF, 32'hD000_0000);

        z = '{br: 0, na: 0, ack: 0, rd: 0, rdy: 0, req: 0, addr: 0, vld: 0, pc: 0, inst: 0};
        drive(z);
        rst = 1'b1;
        @(negedge clk);
        check("reset", z);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hand("idle", 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0);

        foreach (vecs[i]) cycle($sformatf("vec%0d", i), vecs[i]);

        // FULL holding E0 at pc 0, pc_q = 1: asynchronous reset clears everything at once
        hand("full_stall", 0, 32'h0, 0, 32'h0, 0, 0, 32'h1, 1, 32'h0, 32'hE000_0000);
        #2 rst = 1'b1;
        #1 check("rst_in_full", z);
        @(posedge clk);
        #1 rst = 1'b0;
        hand("idle2", 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        hand("fetch0", 0, 32'h0, 1, 32'hF000_0000, 1, 1, 32'h0, 0, 32'h0, 32'h0);
        hand("full0", 0, 32'h0, 0, 32'h0, 1, 0, 32'h1, 1, 32'h0, 32'hF000_0000);
        // request to 1 outstanding: reset abandons it
        drive(z);
        @(negedge clk);
        check("req1_pending", '{br: 0, na: 0, ack: 0, rd: 0, rdy: 0, req: 1, addr: 32'h1,
                                vld: 0, pc: 0, inst: 32'hF000_0000});
        #2 rst = 1'b1;
        #1 check("rst_mid_req", z);
        @(posedge clk);
        #1 rst = 1'b0;
        hand("idle3", 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        hand("refetch0", 0, 32'h0, 0, 32'h0, 1, 1, 32'h0, 0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake. It delivers one fetched instruction at a time to the decode stage over a valid/ready handshake. It also applies branch redirects, including a redirect that arrives while a memory request is still outstanding. It sits between the instruction memory and the IF/ID pipeline register.

## Interface
- `ADDR_W`, default 32: instruction address width, matching `InstAddrBus`.
- `INST_W`, default 32: instruction width, matching `InstBus`.
- `RESET_ADDR`, default 0: first fetch address after reset.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset; asynchronous, active-high.
- `branch_true`  in  1: redirect pulse, one cycle per redirect.
- `new_addr`  in  ADDR_W: redirect target; sampled when `branch_true`=1.
- `imem_req`  out  1: memory request.
- `imem_addr`  out  ADDR_W: request address.
- `imem_ack`  in  1: memory response valid; may be asserted in the same cycle as the request or later.
- `imem_rdata`  in  INST_W: instruction data; valid when `imem_ack`=1.
- `if_valid`  out  1: fetched instruction available to decode.
- `if_ready`  in  1: decode accepts the instruction (low = stall).
- `if_pc`  out  ADDR_W: address of the held instruction.
- `if_inst`  out  INST_W: the held instruction.

## Operation
- Registers:
  - `pc_q`: address of the current or next request.
  - `tgt_q`: pending redirect target.
  - `state`: one of IDLE, FETCH, FULL, DRAIN.
  - Output slot: `if_valid`, `if_pc`, `if_inst`.
- Output decode:
  - `imem_req` = 1 in FETCH and DRAIN; 0 in IDLE and FULL.
  - `imem_addr` = `pc_q` in all states.
- IDLE: entered only from reset. Unconditionally moves to FETCH on the next edge.
- FETCH:
  - `imem_ack` without redirect: capture `imem_rdata` into `if_inst` and `pc_q` into `if_pc`; set `if_valid`=1; `pc_q` <= `pc_q`+1; go to FULL.
  - No ack: stay in FETCH; `imem_req` and `imem_addr` are held stable.
- FULL:
  - `if_ready`=1: `if_valid` <= 0; go to FETCH.
  - Otherwise: hold all outputs.
- DRAIN: a discarded request is still outstanding.
  - `imem_ack`: drop the data; `pc_q` <= `tgt_q`; go to FETCH.
- Redirect (`branch_true`=1) has priority over all of the above and always sets `if_valid` <= 0 (flush):
  - IDLE or FULL: `pc_q` <= `new_addr`; go to FETCH.
  - FETCH with `imem_ack` in the same cycle: drop the data; `pc_q` <= `new_addr`; go to FETCH.
  - FETCH without ack: `tgt_q` <= `new_addr`; go to DRAIN. `pc_q` is unchanged because the old address stays on the bus until ack.
  - DRAIN without ack: `tgt_q` <= `new_addr`; the newest target wins.
  - DRAIN with ack: `pc_q` <= `new_addr`; go to FETCH.
- Redirect with `if_ready`=1 in FULL: the flush wins. The instruction counts as consumed and is not replayed.
- Arithmetic: `pc_q`+1 is word-granular and modulo 2^ADDR_W; all-ones wraps to 0.

## Timing
- Reset values (applied asynchronously):
  - state = IDLE; `pc_q` = `RESET_ADDR`; `tgt_q` = 0.
  - `imem_req` = 0; `if_valid` = 0; `if_pc` = 0; `if_inst` = 0.
- First `imem_req`: the first clock edge after `rst` deasserts moves to FETCH, so `imem_req` asserts in the following cycle.
- Latency with a zero-wait memory (ack in the request cycle): `if_valid` rises one edge after the request cycle.
- Throughput: at most one instruction per 2 cycles (FETCH, then FULL).
- At most one request is outstanding. `imem_req` never drops before `imem_ack`, except on `rst`.
- Reset mid-request: the request is abandoned. The memory shares `rst` and must discard it.
- Redirect-to-first-fetch latency:
  - From IDLE, FULL, or FETCH with a same-cycle ack: 1 cycle.
  - From DRAIN: the remaining memory latency plus 1 cycle.

## Structure
- Shared package `fetch_pkg` holds:
  - the `fetch_state_e` enum (IDLE, FETCH, FULL, DRAIN);
  - `ADDR_W`, `INST_W` and `RESET_ADDR` defaults, kept consistent with `InstAddrBus` and `InstBus`.
- Sub-module `fetch_slot`: the output register. It has capture, clear (flush) and hold controls and owns `if_valid`, `if_pc` and `if_inst`.
- `fetch_ctrl` contains the FSM, `pc_q` and `tgt_q`.

## Test plan
- Reset, then zero-wait memory with `if_ready`=1 held: `imem_addr` sequence is 0, 1, 2; `if_pc` sequence is 0, 1, 2; `if_valid` is high every second cycle.
- Memory acks 3 cycles late: `imem_req` and `imem_addr`=5 stay stable for all 3 cycles, then `if_inst` = the returned data and `if_pc`=5.
- `if_ready`=0 for 4 cycles in FULL: `if_valid`, `if_pc` and `if_inst` hold, `imem_req`=0; on release, the next request is `pc_q`+1.
- Redirect to 0x40 while the request to 7 is pending, with the ack 2 cycles later: DRAIN is entered; the data for 7 never appears; the next request is 0x40. A second redirect to 0x80 inside DRAIN results in the next request being 0x80.
- Redirect in the same cycle as an ack, and redirect while FULL with `if_ready`=1: `if_valid`=0 on the next cycle, and the next request is the target.
- `pc_q`=all-ones fetched: the next request is 0. Asserting `rst` mid-request immediately forces `imem_req`=0, `if_valid`=0, and `pc_q`=`RESET_ADDR`.
